// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage: default widths, opcode field bounds,
// reset PC and timeout length.
package fetch_unit_pkg;

  localparam int unsigned PC_W_DEF           = 8;
  localparam int unsigned INSTR_W_DEF        = 16;
  localparam int unsigned OPCODE_HI          = 15;
  localparam int unsigned OPCODE_LO          = 11;
  localparam int unsigned OPCODE_W           = OPCODE_HI - OPCODE_LO + 1;
  localparam int unsigned RESET_PC_DEF       = 0;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 15;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and IR and runs a req/ack handshake with instruction memory.
// Optional FETCH_TIMEOUT_EN adds a WAIT-state watchdog that raises a sticky fault.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W           = PC_W_DEF,
  parameter int unsigned INSTR_W        = INSTR_W_DEF,
  parameter int unsigned RESET_PC       = RESET_PC_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_req,
  input  logic                pc_load,
  input  logic [PC_W-1:0]     pc_load_value,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_data,
  output logic [INSTR_W-1:0]  ir,
  output logic [OPCODE_W-1:0] opcode,
  output logic                ir_valid,
  output logic                busy,
  output logic [PC_W-1:0]     pc,
  output logic                fault
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          state;
  logic            pend_valid;
  logic [PC_W-1:0] pend_pc;
  logic            timeout_c;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Fires on the WAIT cycle that would complete the allowed number of ack-less cycles.
  assign timeout_c = (state == S_WAIT) && !imem_ack &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        wait_cnt <= '0;
      end else if (!imem_ack) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (timeout_c) begin
        fault <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign timeout_c      = 1'b0;
  assign fault          = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign opcode = ir[OPCODE_HI:OPCODE_LO];
  assign busy   = (state == S_WAIT);

  // Fetch FSM with PC, IR and pending-jump bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= PC_W'(RESET_PC);
      ir         <= '0;
      ir_valid   <= 1'b0;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pc_load) begin
            pc <= pc_load_value;
          end
          if (fetch_req) begin
            imem_addr  <= pc_load ? pc_load_value : pc;
            imem_req   <= 1'b1;
            ir_valid   <= 1'b0;
            pend_valid <= 1'b0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            ir         <= imem_data;
            ir_valid   <= 1'b1;
            imem_req   <= 1'b0;
            pend_valid <= 1'b0;
            state      <= S_IDLE;
            // A jump arriving on the ack cycle is the most recent one and wins.
            if (pc_load) begin
              pc <= pc_load_value;
            end else if (pend_valid) begin
              pc <= pend_pc;
            end else begin
              pc <= imem_addr + PC_W'(1);
            end
          end else if (timeout_c) begin
            imem_req   <= 1'b0;
            ir_valid   <= 1'b0;
            pend_valid <= 1'b0;
            state      <= S_IDLE;
          end else if (pc_load) begin
            pend_valid <= 1'b1;
            pend_pc    <= pc_load_value;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
